parking_slot_controller: RTL and testbench

- Sequences one parking transaction: arms the keypad plate-capture block, waits for a complete 6-digit plate, then either assigns a free slot (entry) or releases the matching slot (exit).
- Keeps a per-slot table: occupied flag, 24-bit plate, minutes parked. On exit it computes the fee.
- Drives the barrier and the status outputs.
- Sits between the front-panel buttons, the plate-capture block and the display/barrier drivers.

---
 rtl/parking_pkg.sv | 36 +++
 rtl/parking_slot_table.sv | 51 +++++
 rtl/parking_slot_controller.sv | 188 ++++++++++++++++++
 tb/tb_parking_slot_controller.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking slot controller: FSM states,
// error codes, field widths and the saturating fee helper.
package parking_pkg;

  localparam int PLACA_W = 24;
  localparam int COBRO_W = 16;
  localparam int MIN_W   = 16;
  localparam int FULL_W  = MIN_W + 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURA,
    ST_BUSCA,
    ST_ACTUALIZA,
    ST_ABRE,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LLENO   = 2'd1,
    ERR_PLACA   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

  // A stay shorter than one minute is billed as one minute.
  function automatic logic [COBRO_W-1:0] sat_fee(input logic [MIN_W-1:0] minutes,
                                                 input logic [31:0] tarifa);
    logic [MIN_W-1:0]  charged;
    logic [FULL_W-1:0] full;
    charged = (minutes == '0) ? MIN_W'(1) : minutes;
    full    = FULL_W'(charged) * FULL_W'(tarifa);
    sat_fee = (full > FULL_W'(16'hFFFF)) ? '1 : full[COBRO_W-1:0];
  endfunction

endpackage

// File: rtl/parking_slot_table.sv
// Per-slot storage (occupied flag, plate, minutes parked) with one
// combinational read port, one write port and the per-minute ageing.
module parking_slot_table
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int IDX_W     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_min,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_occ,
  output logic [PLACA_W-1:0] rd_plate,
  output logic [MIN_W-1:0]   rd_min,
  input  logic               wr_en,
  input  logic               wr_set,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [PLACA_W-1:0] wr_plate
);

  logic               occ     [NUM_SLOTS];
  logic [PLACA_W-1:0] plate   [NUM_SLOTS];
  logic [MIN_W-1:0]   minutes [NUM_SLOTS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        occ[i]     <= 1'b0;
        plate[i]   <= '0;
        minutes[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        // A write to a slot takes priority over that slot's minute tick.
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          occ[i]     <= wr_set;
          plate[i]   <= wr_set ? wr_plate : '0;
          minutes[i] <= '0;
        end else if (tick_min && occ[i] && (minutes[i] != '1)) begin
          minutes[i] <= minutes[i] + MIN_W'(1);
        end
      end
    end
  end

  assign rd_occ   = occ[rd_idx];
  assign rd_plate = plate[rd_idx];
  assign rd_min   = minutes[rd_idx];

endmodule

// File: rtl/parking_slot_controller.sv
// Transaction sequencer for one parking gate: plate capture, linear slot
// scan, table update with fee calculation, and barrier timing.
module parking_slot_controller
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS       = 8,
  parameter int TARIFA          = 50,
  parameter int GATE_CYCLES     = 50_000_000,
  parameter int CAPTURE_TIMEOUT = 500_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_entrada,
  input  logic               btn_salida,
  input  logic [PLACA_W-1:0] placa,
  input  logic               tick_min,
  output logic               ingplaca,
  output logic [3:0]         slot_idx,
  output logic               barrera,
  output logic [COBRO_W-1:0] cobro,
  output logic [4:0]         ocupados,
  output logic               lleno,
  output logic [1:0]         error,
  output logic               busy
);

  localparam int IDX_W = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1;

  state_t             state, state_next;
  err_t               err_q, err_code;
  logic               mode_exit;
  logic [PLACA_W-1:0] plate_reg;
  logic [3:0]         scan_idx, free_idx, match_idx, sel_free, sel_match;
  logic               found_free, found_match, any_free, any_match, cur_match;
  logic               scan_last, tmo_done, gate_done;
  logic [31:0]        tmo_cnt, gate_cnt;
  logic               rd_occ;
  logic [PLACA_W-1:0] rd_plate;
  logic [MIN_W-1:0]   rd_min;

  parking_slot_table #(
    .NUM_SLOTS (NUM_SLOTS),
    .IDX_W     (IDX_W)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_min (tick_min),
    .rd_idx   (scan_idx[IDX_W-1:0]),
    .rd_occ   (rd_occ),
    .rd_plate (rd_plate),
    .rd_min   (rd_min),
    .wr_en    (state == ST_ACTUALIZA),
    .wr_set   (!mode_exit),
    .wr_idx   (scan_idx[IDX_W-1:0]),
    .wr_plate (plate_reg)
  );

  // Scan bookkeeping including the slot being read this cycle.
  assign cur_match = rd_occ && (rd_plate == plate_reg);
  assign any_free  = found_free | ~rd_occ;
  assign any_match = found_match | cur_match;
  assign sel_free  = found_free  ? free_idx  : scan_idx;
  assign sel_match = found_match ? match_idx : scan_idx;
  assign scan_last = (scan_idx == 4'(NUM_SLOTS - 1));
  assign tmo_done  = (tmo_cnt == 32'(CAPTURE_TIMEOUT - 1));
  assign gate_done = (gate_cnt == 32'(GATE_CYCLES - 1));
  assign error     = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_code   = ERR_NONE;
    ingplaca   = 1'b0;
    barrera    = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (btn_entrada) begin
          if (lleno) begin
            state_next = ST_ERROR;
            err_code   = ERR_LLENO;
          end else begin
            state_next = ST_CAPTURA;
          end
        end else if (btn_salida) begin
          state_next = ST_CAPTURA;
        end
      end
      ST_CAPTURA: begin
        ingplaca = 1'b1;
        if (placa != '0) begin
          state_next = ST_BUSCA;
        end else if (tmo_done) begin
          state_next = ST_ERROR;
          err_code   = ERR_TIMEOUT;
        end
      end
      ST_BUSCA: begin
        if (scan_last) begin
          if (mode_exit ? !any_match : any_match) begin
            state_next = ST_ERROR;
            err_code   = ERR_PLACA;
          end else if (!mode_exit && !any_free) begin
            state_next = ST_ERROR;
            err_code   = ERR_LLENO;
          end else begin
            state_next = ST_ACTUALIZA;
          end
        end
      end
      ST_ACTUALIZA: state_next = ST_ABRE;
      ST_ABRE: begin
        barrera = 1'b1;
        if (gate_done) state_next = ST_IDLE;
      end
      ST_ERROR: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q       <= ERR_NONE;
      mode_exit   <= 1'b0;
      plate_reg   <= '0;
      scan_idx    <= '0;
      free_idx    <= '0;
      match_idx   <= '0;
      found_free  <= 1'b0;
      found_match <= 1'b0;
      tmo_cnt     <= '0;
      gate_cnt    <= '0;
      slot_idx    <= '0;
      cobro       <= '0;
      ocupados    <= '0;
      lleno       <= 1'b0;
    end else begin
      if (state_next == ST_ERROR) err_q <= err_code;
      case (state)
        ST_IDLE: begin
          if (state_next == ST_CAPTURA) begin
            mode_exit <= !btn_entrada;
            err_q     <= ERR_NONE;
            tmo_cnt   <= '0;
          end
        end
        ST_CAPTURA: begin
          if (placa != '0) begin
            plate_reg   <= placa;
            scan_idx    <= '0;
            found_free  <= 1'b0;
            found_match <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        ST_BUSCA: begin
          found_free  <= any_free;
          free_idx    <= sel_free;
          found_match <= any_match;
          match_idx   <= sel_match;
          // At the end of the scan, park the read/write address on the target slot.
          if (scan_last) scan_idx <= mode_exit ? sel_match : sel_free;
          else           scan_idx <= scan_idx + 4'd1;
        end
        ST_ACTUALIZA: begin
          slot_idx <= scan_idx;
          gate_cnt <= '0;
          if (mode_exit) begin
            cobro    <= sat_fee(rd_min, 32'(TARIFA));
            ocupados <= ocupados - 5'd1;
            lleno    <= 1'b0;
          end else begin
            ocupados <= ocupados + 5'd1;
            lleno    <= ((ocupados + 5'd1) == 5'(NUM_SLOTS));
          end
        end
        ST_ABRE: gate_cnt <= gate_cnt + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_slot_controller.sv
// Bench for parking_slot_controller: directed vector table, corner sequences
// (saturation, tick/write collision, reset in ABRE) and random transactions.
module tb_parking_slot_controller;
  import parking_pkg::*;

  localparam int NS   = 4;
  localparam int TAR  = 50;
  localparam int GATE = 10;
  localparam int CT   = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_entrada = 1'b0;
  logic        btn_salida = 1'b0;
  logic        tick_min = 1'b0;
  logic [23:0] placa = '0;
  logic        ingplaca, barrera, lleno, busy;
  logic [3:0]  slot_idx;
  logic [15:0] cobro;
  logic [4:0]  ocupados;
  logic [1:0]  error;

  always #5 clk = ~clk;

  parking_slot_controller #(
    .NUM_SLOTS       (NS),
    .TARIFA          (TAR),
    .GATE_CYCLES     (GATE),
    .CAPTURE_TIMEOUT (CT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_entrada (btn_entrada),
    .btn_salida  (btn_salida),
    .placa       (placa),
    .tick_min    (tick_min),
    .ingplaca    (ingplaca),
    .slot_idx    (slot_idx),
    .barrera     (barrera),
    .cobro       (cobro),
    .ocupados    (ocupados),
    .lleno       (lleno),
    .error       (error),
    .busy        (busy)
  );

  int    checks = 0;
  int    errors = 0;
  string phase  = "reset";
  int    cur_id = 0;

  // Reference model: the parking lot as plain arrays.
  bit          m_occ   [NS];
  logic [23:0] m_plate [NS];
  int          m_min   [NS];
  int          m_cnt;
  logic [15:0] m_cobro;
  logic [3:0]  m_slot;
  logic [1:0]  m_err;

  typedef struct {
    bit          is_exit;
    bit          both;
    logic [23:0] plate;
    int          delay;
    int          ticks;
    logic [1:0]  err;
    logic [3:0]  slot;
    logic [15:0] cobro;
    logic [4:0]  ocup;
  } vec_t;

  vec_t vecs [16];
  int   ing_n, busy_n, gate_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] %s actual=%0h expected=%0h", phase, cur_id, name, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NS; i++) begin
      m_occ[i] = 0; m_plate[i] = '0; m_min[i] = 0;
    end
    m_cnt = 0; m_cobro = '0; m_slot = '0; m_err = '0;
  endfunction

  function automatic void m_ticks(input int n);
    for (int i = 0; i < NS; i++)
      if (m_occ[i]) m_min[i] = (m_min[i] + n > 65535) ? 65535 : m_min[i] + n;
  endfunction

  function automatic void m_txn(input bit is_exit, input logic [23:0] p, input int delay);
    int hit, free, fee;
    hit = -1; free = -1;
    m_err = 2'd0;
    if (!is_exit && m_cnt == NS) begin m_err = 2'd1; return; end
    if (delay >= CT) begin m_err = 2'd3; return; end
    for (int i = 0; i < NS; i++) begin
      if (m_occ[i] && m_plate[i] == p && hit < 0) hit = i;
      if (!m_occ[i] && free < 0) free = i;
    end
    if (!is_exit) begin
      if (hit >= 0) m_err = 2'd2;
      else begin
        m_occ[free] = 1; m_plate[free] = p; m_min[free] = 0;
        m_slot = 4'(free); m_cnt++;
      end
    end else if (hit < 0) begin
      m_err = 2'd2;
    end else begin
      fee = ((m_min[hit] < 1) ? 1 : m_min[hit]) * TAR;
      m_cobro = (fee > 65535) ? 16'hFFFF : 16'(fee);
      m_occ[hit] = 0; m_plate[hit] = '0; m_min[hit] = 0;
      m_slot = 4'(hit); m_cnt--;
    end
  endfunction

  // Expected cycle counts of a transaction from its outcome.
  function automatic void exp_timing(input logic [1:0] e, input int delay,
                                     output int x_ing, output int x_busy, output int x_gate);
    x_gate = 0;
    case (e)
      2'd1:    begin x_ing = 0;         x_busy = 1; end
      2'd3:    begin x_ing = CT;        x_busy = CT + 1; end
      2'd2:    begin x_ing = delay + 1; x_busy = delay + 1 + NS + 1; end
      default: begin x_ing = delay + 1; x_busy = delay + 1 + NS + 1 + GATE; x_gate = GATE; end
    endcase
  endfunction

  task automatic do_ticks(input int n);
    repeat (n) begin
      tick_min = 1'b1;
      @(negedge clk);
      tick_min = 1'b0;
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at the first idle negedge.
  task automatic run_txn(input bit is_exit, input bit both, input logic [23:0] p,
                         input int delay, input bit hold,
                         output int o_ing, output int o_busy, output int o_gate);
    btn_entrada = !is_exit || both;
    btn_salida  = is_exit || both;
    tick_min    = hold;
    @(negedge clk);
    btn_entrada = 1'b0;
    btn_salida  = 1'b0;
    o_ing = 0; o_busy = 0; o_gate = 0;
    while (busy && o_busy < 200) begin
      o_busy++;
      if (ingplaca) begin
        o_ing++;
        if (o_ing > delay) placa = p;
      end
      if (barrera) o_gate++;
      @(negedge clk);
    end
    tick_min = 1'b0;
    placa    = '0;
    chk("txn_done", 32'(busy), 32'd0);
  endtask

  task automatic check_txn(input logic [1:0] e, input logic [3:0] s, input logic [15:0] c,
                           input logic [4:0] o, input int delay);
    int x_ing, x_busy, x_gate;
    exp_timing(e, delay, x_ing, x_busy, x_gate);
    chk("error",    32'(error),    32'(e));
    chk("slot_idx", 32'(slot_idx), 32'(s));
    chk("cobro",    32'(cobro),    32'(c));
    chk("ocupados", 32'(ocupados), 32'(o));
    chk("lleno",    32'(lleno),    32'(o == 5'(NS)));
    chk("barrera_idle", 32'(barrera), 32'd0);
    chk("ing_cycles",  32'(ing_n),  32'(x_ing));
    chk("busy_cycles", 32'(busy_n), 32'(x_busy));
    chk("gate_cycles", 32'(gate_n), 32'(x_gate));
  endtask

  initial begin
    vecs[0]  = '{0, 0, 24'h123456,  5, 0, 2'd0, 4'd0, 16'd0,   5'd1};
    vecs[1]  = '{1, 0, 24'h123456,  0, 3, 2'd0, 4'd0, 16'd150, 5'd0};
    vecs[2]  = '{0, 1, 24'h123456,  2, 0, 2'd0, 4'd0, 16'd150, 5'd1};
    vecs[3]  = '{1, 0, 24'h123456,  1, 0, 2'd0, 4'd0, 16'd50,  5'd0};
    vecs[4]  = '{0, 0, 24'h111111,  0, 0, 2'd0, 4'd0, 16'd50,  5'd1};
    vecs[5]  = '{0, 0, 24'h222222,  3, 0, 2'd0, 4'd1, 16'd50,  5'd2};
    vecs[6]  = '{0, 0, 24'h333333,  0, 0, 2'd0, 4'd2, 16'd50,  5'd3};
    vecs[7]  = '{0, 0, 24'h444444,  0, 0, 2'd0, 4'd3, 16'd50,  5'd4};
    vecs[8]  = '{0, 0, 24'h555555,  0, 0, 2'd1, 4'd3, 16'd50,  5'd4};
    vecs[9]  = '{1, 0, 24'h222222,  0, 2, 2'd0, 4'd1, 16'd100, 5'd3};
    vecs[10] = '{0, 0, 24'h333333,  0, 0, 2'd2, 4'd1, 16'd100, 5'd3};
    vecs[11] = '{1, 0, 24'h999999,  4, 0, 2'd2, 4'd1, 16'd100, 5'd3};
    vecs[12] = '{0, 0, 24'h666666, 19, 0, 2'd0, 4'd1, 16'd100, 5'd4};
    vecs[13] = '{1, 0, 24'h777777, 30, 0, 2'd3, 4'd1, 16'd100, 5'd4};
    vecs[14] = '{1, 0, 24'h111111,  0, 0, 2'd0, 4'd0, 16'd100, 5'd3};
    vecs[15] = '{0, 0, 24'hABCDEF, 25, 0, 2'd3, 4'd0, 16'd100, 5'd3};

    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_ingplaca", 32'(ingplaca), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_barrera",  32'(barrera),  32'd0);
    chk("rst_outputs",  {slot_idx, cobro, ocupados, lleno, error}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    phase = "table";
    for (int i = 0; i < 16; i++) begin
      cur_id = i;
      do_ticks(vecs[i].ticks);
      m_ticks(vecs[i].ticks);
      run_txn(vecs[i].is_exit, vecs[i].both, vecs[i].plate, vecs[i].delay, 1'b0,
              ing_n, busy_n, gate_n);
      m_txn(vecs[i].is_exit, vecs[i].plate, vecs[i].delay);
      check_txn(vecs[i].err, vecs[i].slot, vecs[i].cobro, vecs[i].ocup, vecs[i].delay);
    end

    phase = "saturate"; cur_id = 0;
    do_ticks(1400);
    m_ticks(1400);
    run_txn(1'b1, 1'b0, 24'h333333, 0, 1'b0, ing_n, busy_n, gate_n);
    m_txn(1'b1, 24'h333333, 0);
    check_txn(m_err, m_slot, m_cobro, 5'(m_cnt), 0);
    chk("cobro_sat", 32'(cobro), 32'h0000FFFF);

    // tick_min held through a whole entry: it collides with the table write.
    phase = "tick_collide"; cur_id = 0;
    run_txn(1'b0, 1'b0, 24'h0A0A0A, 0, 1'b1, ing_n, busy_n, gate_n);
    m_ticks(1 + 0 + 1 + NS + 1);
    m_txn(1'b0, 24'h0A0A0A, 0);
    m_ticks(GATE);
    check_txn(m_err, m_slot, m_cobro, 5'(m_cnt), 0);
    cur_id = 1;
    run_txn(1'b1, 1'b0, 24'h0A0A0A, 0, 1'b0, ing_n, busy_n, gate_n);
    m_txn(1'b1, 24'h0A0A0A, 0);
    check_txn(m_err, m_slot, m_cobro, 5'(m_cnt), 0);
    chk("cobro_after_collide", 32'(cobro), 32'd500);

    phase = "reset_abre"; cur_id = 0;
    btn_entrada = 1'b1;
    @(negedge clk);
    btn_entrada = 1'b0;
    placa = 24'h5A5A5A;
    for (int n = 0; n < 100 && !barrera; n++) @(negedge clk);
    chk("reach_abre", 32'(barrera), 32'd1);
    m_txn(1'b0, 24'h5A5A5A, 0);
    @(negedge clk);
    chk("ocup_before_rst", 32'(ocupados), 32'(m_cnt));
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_barrera", 32'(barrera),  32'd0);
    chk("rst_busy",    32'(busy),     32'd0);
    chk("rst_ocup",    32'(ocupados), 32'd0);
    chk("rst_outputs", {slot_idx, cobro, ocupados, lleno, error}, 32'd0);
    rst_n = 1'b1;
    placa = '0;
    m_reset();
    @(negedge clk);
    cur_id = 1;
    run_txn(1'b1, 1'b0, 24'h444444, 0, 1'b0, ing_n, busy_n, gate_n);
    m_txn(1'b1, 24'h444444, 0);
    check_txn(m_err, m_slot, m_cobro, 5'(m_cnt), 0);
    chk("post_rst_exit_err", 32'(error), 32'd2);
    cur_id = 2;
    run_txn(1'b0, 1'b0, 24'h777777, 1, 1'b0, ing_n, busy_n, gate_n);
    m_txn(1'b0, 24'h777777, 1);
    check_txn(m_err, m_slot, m_cobro, 5'(m_cnt), 1);
    chk("post_rst_slot", 32'(slot_idx), 32'd0);

    phase = "random";
    for (int t = 0; t < 40; t++) begin
      bit          ex;
      logic [23:0] p;
      int          d, tk;
      cur_id = t;
      ex = 1'($urandom_range(0, 1));
      p  = 24'h100000 + 24'($urandom_range(1, 6));
      d  = $urandom_range(0, 21);
      tk = $urandom_range(0, 3);
      do_ticks(tk);
      m_ticks(tk);
      run_txn(ex, 1'($urandom_range(0, 3) == 0) & !ex, p, d, 1'b0, ing_n, busy_n, gate_n);
      m_txn(ex, p, d);
      check_txn(m_err, m_slot, m_cobro, 5'(m_cnt), d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
